button_event_gen: RTL and testbench

Converts the clean, debounced button level produced by the debouncer stage into one-cycle game command events: press, release, long-press and auto-repeat ticks, plus a registered held flag. It sits directly downstream of the debouncer and upstream of the T-rex game control logic, for example jump on press and duck or fast-repeat on long hold. All outputs are registered, and every event output is a single-cycle pulse in the `clk` domain.

---
 rtl/button_event_gen.sv | 81 ++++++++
 tb/tb_button_event_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into press/release/long-press/repeat pulses plus a held flag
module button_event_gen #(
  parameter int              CNT_W         = 24,
  parameter logic [CNT_W-1:0] LONG_CYCLES   = 24'd5_000_000,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = 24'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  input  logic enable,
  output logic press,
  output logic released,
  output logic long_press,
  output logic repeat_tick,
  output logic held
);
  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
  localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYCLES - 1'b1;
  localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_CYCLES - 1'b1;
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             lvl_q, rise, p_n, r_n, l_n, t_n;
  assign rise = btn_level & ~lvl_q;
  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    p_n   = 1'b0;
    r_n   = 1'b0;
    l_n   = 1'b0;
    t_n   = 1'b0;
    if (!enable) begin
      nxt   = IDLE;
      cnt_n = '0;
    end else begin
      unique case (state)
        IDLE: if (rise) begin
          nxt   = PRESSED;
          cnt_n = '0;
          p_n   = 1'b1;
        end
        PRESSED: begin
          nxt   = !btn_level ? IDLE : (cnt == LONG_LAST) ? LONG : PRESSED;
          r_n   = !btn_level;
          l_n   = btn_level && cnt == LONG_LAST;
          cnt_n = (!btn_level || cnt == LONG_LAST) ? '0 : cnt + 1'b1;
        end
        LONG: begin
          nxt   = btn_level ? LONG : IDLE;
          r_n   = !btn_level;
          t_n   = btn_level && cnt == REP_LAST;
          cnt_n = (!btn_level || cnt == REP_LAST) ? '0 : cnt + 1'b1;
        end
        default: begin
          nxt   = IDLE;
          cnt_n = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lvl_q       <= 1'b1;
      press       <= 1'b0;
      released    <= 1'b0;
      long_press  <= 1'b0;
      repeat_tick <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= cnt_n;
      lvl_q       <= btn_level;
      press       <= p_n;
      released    <= r_n;
      long_press  <= l_n;
      repeat_tick <= t_n;
      held        <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: scenario and random checks against a hold-age based reference model
module tb_button_event_gen;
  localparam int LC = 8;
  localparam int RC = 4;
  logic clk = 1'b0, rst_n = 1'b0, btn_level = 1'b0, enable = 1'b0;
  logic press, released, long_press, repeat_tick, held;
  logic [4:0] got, exp_v;
  int total = 0, bad = 0;
  logic m_prev = 1'b1, m_act = 1'b0;
  int m_age = 0;

  button_event_gen #(.CNT_W(24), .LONG_CYCLES(24'd8), .REPEAT_CYCLES(24'd4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .enable(enable),
    .press(press), .released(released), .long_press(long_press),
    .repeat_tick(repeat_tick), .held(held)
  );

  always #5 clk = ~clk;
  assign got = {press, released, long_press, repeat_tick, held};

  // Model: a hold is active from its press edge; events follow from its age in cycles.
  task automatic drive(input logic l, input logic e, input logic r);
    logic rise;
    @(negedge clk);
    btn_level = l;
    enable = e;
    rst_n = r;
    @(posedge clk);
    exp_v = '0;
    if (!r) begin
      m_prev = 1'b1;
      m_act = 1'b0;
    end else begin
      rise = l & ~m_prev;
      m_prev = l;
      if (!e) m_act = 1'b0;
      else if (m_act) begin
        if (!l) begin
          exp_v[3] = 1'b1;
          m_act = 1'b0;
        end else begin
          m_age++;
          exp_v[2] = (m_age == LC);
          exp_v[1] = (m_age > LC) && ((m_age - LC) % RC == 0);
        end
      end else if (rise) begin
        exp_v[4] = 1'b1;
        m_act = 1'b1;
        m_age = 0;
      end
    end
    exp_v[0] = m_act;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      total++;
      if (got !== 5'b0) begin bad++; $display("FAIL reset_state cyc=%0d got=%b exp=00000", i, got); end
    end
    for (int i = 0; i < 12; i++) begin
      drive(i == 8 ? 1'b0 : 1'b1, 1'b1, 1'b1);
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL reset_held cyc=%0d got=%b exp=%b", i, got, exp_v); end
      if (i == 9) begin
        total++;
        if ({press, held} !== 2'b11) begin bad++; $display("FAIL reset_repress got=%b exp=11", {press, held}); end
      end
    end
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_tap();
    int held_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 1'b1, 1'b1);
      held_cnt += held;
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL tap cyc=%0d got=%b exp=%b", i, got, exp_v); end
    end
    total++;
    if (held_cnt !== 3) begin bad++; $display("FAIL tap_held_len got=%0d exp=3", held_cnt); end
  endtask

  task automatic test_long_hold();
    int n_long = 0, n_tick = 0;
    for (int i = 0; i < 24; i++) begin
      drive(i <= 20, 1'b1, 1'b1);
      n_long += long_press;
      n_tick += repeat_tick;
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL long_hold cyc=%0d got=%b exp=%b", i, got, exp_v); end
    end
    total++;
    if (n_long !== 1 || n_tick !== 3) begin bad++; $display("FAIL long_counts got=%0d/%0d exp=1/3", n_long, n_tick); end
  endtask

  task automatic test_coincide();
    for (int i = 0; i < 11; i++) begin
      drive(i < 8, 1'b1, 1'b1);
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL coincide cyc=%0d got=%b exp=%b", i, got, exp_v); end
      if (i == 8) begin
        total++;
        if ({released, long_press} !== 2'b10) begin bad++; $display("FAIL coincide_rel got=%b exp=10", {released, long_press}); end
      end
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 16; i++) begin
      drive(i != 12, !(i == 5 || i == 6), 1'b1);
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL enable_drop cyc=%0d got=%b exp=%b", i, got, exp_v); end
    end
    drive(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(i != 2 && i != 5, 1'b1, 1'b1);
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, got, exp_v); end
    end
    drive(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 1'b1, i != 6);
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL mid_reset cyc=%0d got=%b exp=%b", i, got, exp_v); end
    end
    drive(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    int run = 0;
    logic l = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        l = ~l;
        run = l ? $urandom_range(1, 30) : $urandom_range(1, 6);
      end
      run--;
      drive(l, $urandom_range(0, 40) != 0, $urandom_range(0, 150) != 0);
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%b exp=%b", i, got, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_long_hold();
    test_coincide();
    test_enable_drop();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
